bcd_countdown_timer: RTL
========================

Name: bcd_countdown_timer

Overview:
- Cooking-time countdown stage that sits directly downstream of the 2:1 tick mux. It consumes the mux output (either the divide-by-100 seconds tick or the delay-path tick) as its count-enable.
- It holds the programmed time as four BCD digits (MM:SS), counts down to 00:00, and flags completion to the control/alarm logic.
- It is fully synchronous to the system clock. The tick input is edge-detected and never used as a clock.

Parameters:
- MIN_TENS_MAX, 9, largest legal minutes-tens digit; larger loaded values clamp to this.
- SEC_TENS_MAX, 5, largest legal seconds-tens digit; larger loaded values clamp to this.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- tick  input  1  count-enable level from the tick mux; one decrement per 0->1 transition.
- load  input  1  load the preset digits.
- preset  input  16  {min_tens, min_ones, sec_tens, sec_ones}, 4 bits each.
- start  input  1  begin or resume counting.
- stop  input  1  pause counting.
- clear  input  1  zero the count and return to IDLE.
- digits  output  16  current {min_tens, min_ones, sec_tens, sec_ones}, registered.
- running  output  1  high in RUNNING.
- zero  output  1  high when digits == 0.
- done  output  1  one-cycle pulse on entry to DONE.
- alarm  output  1  high while in DONE.

Behaviour:
- Reset: if rst_n is low at a clk edge, then state=IDLE, digits=0, tick_q=0, running=0, done=0, alarm=0, zero=1. Reset takes priority over every other input, including mid-count. No residual done pulse follows reset.
- Tick edge: tick_q is tick registered once. tick_rise = tick & ~tick_q. tick held high yields exactly one decrement.
- States: IDLE, PAUSED, RUNNING, DONE. State is encoded as 2 bits.
- Command priority, evaluated per cycle: clear > load > stop > start > tick_rise.
- clear, any state: digits=0, go to IDLE.
- load, in IDLE, PAUSED or DONE: digits = clamped preset, go to PAUSED.
  - If the clamped preset is 0, go to IDLE instead.
  - load is ignored while RUNNING.
- Clamping:
  - Any ones digit >9 becomes 9.
  - min_tens > MIN_TENS_MAX becomes MIN_TENS_MAX.
  - sec_tens > SEC_TENS_MAX becomes SEC_TENS_MAX.
- stop in RUNNING: go to PAUSED. A same-cycle tick_rise is discarded with no decrement. stop in any other state is a no-op.
- start in PAUSED: go to RUNNING. A same-cycle tick_rise is not applied; the first decrement happens on the next tick_rise. start in IDLE, DONE or RUNNING is a no-op.
- tick_rise in RUNNING decrements the MM:SS value by one second using a BCD borrow chain:
  - sec_ones 0 -> 9, borrow from sec_tens.
  - sec_tens 0 -> SEC_TENS_MAX, borrow from min_ones.
  - min_ones 0 -> 9, borrow from min_tens.
  - Example: 10:00 -> 09:59.
- Decrement from 00:01 gives 00:00 in the same cycle as the transition to DONE. done is high for exactly one cycle, alarm is high from that cycle on.
- The count never wraps below 00:00. tick_rise in IDLE, PAUSED or DONE is ignored.
- DONE holds digits=0 and alarm=1 until clear or load.
- running, alarm and zero are registered and track the state/digits of the same cycle. done is registered, so there is no combinational path from inputs to outputs.
- Latency: a tick 0->1 sampled at edge N is reflected on digits after edge N+1, a fixed 1-cycle edge-detect delay.

Decomposition:
- Shared package timer_pkg holds:
  - state typedef/localparams (ST_IDLE=0, ST_PAUSED=1, ST_RUNNING=2, ST_DONE=3);
  - BCD digit width (4);
  - default digit maxima.
- One sub-module: bcd_digit_dec.
  - Inputs: digit, max, borrow_in.
  - Outputs: next digit, borrow_out.
  - Instantiated four times in a borrow chain.
- Edge detector, FSM and clamping stay in the top.

Test Plan:
- Reset mid-run: load 00:05, start, 2 ticks, assert rst_n=0 for one edge -> digits=0000, state IDLE, running=0, done never pulses.
- Borrow chain: load 10:00, start, 1 tick -> digits=0959. 60 more ticks -> 0859.
- Completion: load 00:02, start, 3 ticks -> 00:01, then 00:00 with done high exactly 1 cycle and alarm=1. The 3rd tick leaves 0000. load 00:03 -> alarm=0, PAUSED.
- Pause/priority: RUNNING at 00:30, stop asserted together with tick_rise -> stays 00:30, PAUSED. start together with tick_rise -> still 00:30, next tick -> 00:29.
- Clamp and ignore: load preset 0xC7FB -> digits 9759. load during RUNNING -> ignored. load 00:00 -> IDLE, start ignored.
- Held tick: tick high for 20 cycles in RUNNING -> exactly one decrement.

Source files
------------

// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding, digit width and digit maxima for the countdown timer
package timer_pkg;
  localparam int DW = 4;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PAUSED = 2'd1;
  localparam logic [1:0] ST_RUNNING = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
  localparam logic [DW-1:0] ONES_MAX = 4'd9;
  localparam logic [DW-1:0] MIN_TENS_MAX_DEF = 4'd9;
  localparam logic [DW-1:0] SEC_TENS_MAX_DEF = 4'd5;
  function automatic logic [DW-1:0] clamp_digit(input logic [DW-1:0] d, input logic [DW-1:0] m);
    return (d > m) ? m : d;
  endfunction
endpackage

// File: rtl/bcd_digit_dec.sv
// bcd_digit_dec: one BCD digit of the borrow chain, wrapping 0 to max on borrow
module bcd_digit_dec
  import timer_pkg::*;
(
  input  logic [DW-1:0] digit,
  input  logic [DW-1:0] max,
  input  logic          borrow_in,
  output logic [DW-1:0] digit_out,
  output logic          borrow_out
);
  always_comb begin
    borrow_out = borrow_in && (digit == '0);
    digit_out = !borrow_in ? digit : (digit == '0) ? max : digit - 1'b1;
  end
endmodule

// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: MM:SS BCD countdown driven by the rising edges of a tick level
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter logic [DW-1:0] MIN_TENS_MAX = MIN_TENS_MAX_DEF,
  parameter logic [DW-1:0] SEC_TENS_MAX = SEC_TENS_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        load,
  input  logic [15:0] preset,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  output logic [15:0] digits,
  output logic        running,
  output logic        zero,
  output logic        done,
  output logic        alarm
);
  localparam logic [15:0] MAXV = {MIN_TENS_MAX, ONES_MAX, SEC_TENS_MAX, ONES_MAX};
  logic [1:0] state_q, state_d;
  logic [15:0] digits_q, digits_d, dec, pre;
  logic [4:0] b;
  logic tick_q, rise_q, rise_d;
  logic running_q, running_d, zero_q, zero_d, done_q, done_d, alarm_q, alarm_d;
  assign b[0] = 1'b1;
  for (genvar i = 0; i < 4; i++) begin : g_dec
    bcd_digit_dec u_dec (
      .digit(digits_q[DW*i+:DW]),
      .max(MAXV[DW*i+:DW]),
      .borrow_in(b[i]),
      .digit_out(dec[DW*i+:DW]),
      .borrow_out(b[i+1])
    );
    assign pre[DW*i+:DW] = clamp_digit(preset[DW*i+:DW], MAXV[DW*i+:DW]);
  end
  // The registered rise gives the fixed one-cycle edge-detect latency
  assign rise_d = tick & ~tick_q;
  always_comb begin
    state_d = state_q;
    digits_d = digits_q;
    if (clear) begin
      state_d = ST_IDLE;
      digits_d = '0;
    end else if (load && state_q != ST_RUNNING) begin
      digits_d = pre;
      state_d = (pre == '0) ? ST_IDLE : ST_PAUSED;
    end else if (stop && state_q == ST_RUNNING) begin
      state_d = ST_PAUSED;
    end else if (start && state_q == ST_PAUSED) begin
      state_d = ST_RUNNING;
    end else if (rise_q && state_q == ST_RUNNING && !b[4]) begin
      digits_d = dec;
      state_d = (dec == '0) ? ST_DONE : ST_RUNNING;
    end
    running_d = state_d == ST_RUNNING;
    alarm_d = state_d == ST_DONE;
    zero_d = digits_d == '0;
    done_d = state_d == ST_DONE && state_q != ST_DONE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      digits_q <= '0;
      tick_q <= 1'b0;
      rise_q <= 1'b0;
      running_q <= 1'b0;
      zero_q <= 1'b1;
      done_q <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      digits_q <= digits_d;
      tick_q <= tick;
      rise_q <= rise_d;
      running_q <= running_d;
      zero_q <= zero_d;
      done_q <= done_d;
      alarm_q <= alarm_d;
    end
  end
  assign digits = digits_q;
  assign running = running_q;
  assign zero = zero_q;
  assign done = done_q;
  assign alarm = alarm_q;
endmodule
